// File: rtl/calc_sequencer.sv
// Calculator key sequencer: assembles operand A, operator and operand B from
// debounced key codes, runs one ALU operation and holds the result for display.
module calc_sequencer #(
    parameter int N_DIGITS = 4,
    parameter int W        = 14,
    parameter int TIMEOUT  = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [3:0]   key,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    input  logic         alu_err,
    output logic [W-1:0] operand_a,
    output logic [W-1:0] operand_b,
    output logic [1:0]   op_codificada,
    output logic         start,
    output logic [W-1:0] display,
    output logic         busy,
    output logic         error
);

    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_A,
        S_B,
        S_EXEC,
        S_SHOW
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   result, result_nxt;
    logic [CW-1:0]  cnt_a, cnt_a_nxt;
    logic [CW-1:0]  cnt_b, cnt_b_nxt;
    logic [TW-1:0]  timer, timer_nxt;
    logic [W-1:0]   a_nxt, b_nxt, display_nxt;
    logic [1:0]     op_nxt;
    logic           start_nxt, busy_nxt, err_nxt;
    logic           is_digit, is_op, is_equals, is_clear;

    // Decimal shift-in; wraps at W bits, which cannot happen for W sized to N_DIGITS
    function automatic logic [W-1:0] acc_digit(input logic [W-1:0] acc, input logic [3:0] d);
        return acc * W'(10) + W'(d);
    endfunction

    function automatic logic [1:0] enc_op(input logic [3:0] k);
        case (k)
            4'hA:    return 2'b11;
            4'hB:    return 2'b10;
            4'hC:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    assign is_digit  = key_valid && (key <= 4'd9);
    assign is_op     = key_valid && (key >= 4'hA) && (key <= 4'hC);
    assign is_equals = key_valid && (key == 4'hD);
    assign is_clear  = key_valid && (key == 4'hE);

    always_comb begin
        state_nxt  = state;
        a_nxt      = operand_a;
        b_nxt      = operand_b;
        op_nxt     = op_codificada;
        result_nxt = result;
        cnt_a_nxt  = cnt_a;
        cnt_b_nxt  = cnt_b;
        timer_nxt  = timer;
        err_nxt    = error;
        start_nxt  = 1'b0;

        // Clear takes priority everywhere, including over a simultaneous alu_done
        if (is_clear) begin
            state_nxt  = S_A;
            a_nxt      = '0;
            b_nxt      = '0;
            op_nxt     = 2'b00;
            result_nxt = '0;
            cnt_a_nxt  = '0;
            cnt_b_nxt  = '0;
            timer_nxt  = '0;
            err_nxt    = 1'b0;
        end else begin
            case (state)
                S_A: begin
                    if (is_digit && (cnt_a < CW'(N_DIGITS))) begin
                        a_nxt     = acc_digit(operand_a, key);
                        cnt_a_nxt = cnt_a + CW'(1);
                    end else if (is_op) begin
                        op_nxt    = enc_op(key);
                        cnt_b_nxt = '0;
                        state_nxt = S_B;
                    end
                end
                S_B: begin
                    if (is_digit && (cnt_b < CW'(N_DIGITS))) begin
                        b_nxt     = acc_digit(operand_b, key);
                        cnt_b_nxt = cnt_b + CW'(1);
                    end else if (is_op && (cnt_b == '0)) begin
                        op_nxt = enc_op(key);
                    end else if (is_equals) begin
                        start_nxt = 1'b1;
                        timer_nxt = '0;
                        state_nxt = S_EXEC;
                    end
                end
                S_EXEC: begin
                    timer_nxt = timer + TW'(1);
                    if (alu_done) begin
                        result_nxt = alu_result;
                        err_nxt    = error | alu_err;
                        state_nxt  = S_SHOW;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        // TIMEOUT full cycles spent in S_EXEC without a reply
                        result_nxt = '0;
                        err_nxt    = 1'b1;
                        state_nxt  = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (is_digit) begin
                        a_nxt      = W'(key);
                        b_nxt      = '0;
                        op_nxt     = 2'b00;
                        result_nxt = '0;
                        cnt_a_nxt  = CW'(1);
                        cnt_b_nxt  = '0;
                        state_nxt  = S_A;
                    end else if (is_op) begin
                        a_nxt     = result;
                        b_nxt     = '0;
                        op_nxt    = enc_op(key);
                        cnt_a_nxt = '0;
                        cnt_b_nxt = '0;
                        state_nxt = S_B;
                    end
                end
                default: state_nxt = S_A;
            endcase
        end

        busy_nxt = (state_nxt == S_EXEC);

        display_nxt = display;
        case (state_nxt)
            S_A:     display_nxt = a_nxt;
            S_B:     display_nxt = (cnt_b_nxt == '0) ? a_nxt : b_nxt;
            S_EXEC:  display_nxt = display;
            S_SHOW:  display_nxt = result_nxt;
            default: display_nxt = display;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_A;
            operand_a     <= '0;
            operand_b     <= '0;
            op_codificada <= 2'b00;
            start         <= 1'b0;
            display       <= '0;
            busy          <= 1'b0;
            error         <= 1'b0;
            result        <= '0;
            cnt_a         <= '0;
            cnt_b         <= '0;
            timer         <= '0;
        end else begin
            state         <= state_nxt;
            operand_a     <= a_nxt;
            operand_b     <= b_nxt;
            op_codificada <= op_nxt;
            start         <= start_nxt;
            display       <= display_nxt;
            busy          <= busy_nxt;
            error         <= err_nxt;
            result        <= result_nxt;
            cnt_a         <= cnt_a_nxt;
            cnt_b         <= cnt_b_nxt;
            timer         <= timer_nxt;
        end
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Keypad-to-ALU controller for the digital calculator.
- Consumes debounced 4-bit key codes and assembles operand A, the operator and operand B.
- Issues a one-cycle start to the ALU, waits for its done, then latches and presents the result.
- Sits between the keypad scanner and the arithmetic datapath; owns the operator encoding (A→11, B→10, C→01, none→00) and the equals key (D).

Parameters:
- N_DIGITS, 4, maximum decimal digits accepted per operand.
- W, 14, operand/result width in bits; must hold 10^N_DIGITS−1.
- TIMEOUT, 255, cycles to wait for alu_done before flagging an error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- key_valid  input  1  one-cycle pulse; key is valid in that cycle.
- key  input  4  key code: 0–9 digit, A/B/C operator, D equals, E clear, F ignored.
- alu_done  input  1  one-cycle pulse; result is valid in that cycle.
- alu_result  input  W  ALU result.
- alu_err  input  1  ALU error (e.g. divide by zero); qualified by alu_done.
- operand_a  output  W  registered operand A to the ALU.
- operand_b  output  W  registered operand B to the ALU.
- op_codificada  output  2  registered encoded operator.
- start  output  1  one-cycle ALU start pulse.
- display  output  W  value to show.
- busy  output  1  high in S_EXEC.
- error  output  1  sticky error flag; cleared by E or rst.

Behaviour:
Reset and keys:
- Reset: asynchronous, active-high. While rst is high, state is S_A and every output is 0.
- Keys are acted on only in cycles with key_valid=1. All other cycles hold state, except alu_done and timeout handling in S_EXEC.
- Key E in any state: clears operands, operator, digit counters and error; goes to S_A. Output registers update on the next edge.
- Key F: always ignored.

Digit entry:
- Accumulator update: acc ← acc*10 + key, computed at W bits.
- A digit is accepted only while digit count < N_DIGITS; extra digits are silently dropped.
- Leading zeros count as digits.

S_A (enter operand A):
- Digit: accumulate into operand_a.
- A/B/C: latch op_codificada; go to S_B. Zero digits entered means A=0.
- D: ignored.

S_B (enter operand B):
- Digit: accumulate into operand_b.
- A/B/C with zero B digits: replace the operator.
- A/B/C with B digits entered: ignored.
- D: start=1 for exactly one cycle, on the edge after the key; go to S_EXEC. Zero B digits means B=0.

S_EXEC:
- busy=1.
- Digit and operator keys are ignored. E aborts the operation (abort wins over a simultaneous alu_done).
- alu_done: latch alu_result into the result register; set error if alu_err=1; go to S_SHOW.
- Timeout counter starts at 0 on entry. When it reaches TIMEOUT with no alu_done: error=1, go to S_SHOW, result register holds 0.
- An alu_done in any other state is ignored.

S_SHOW:
- Digit: clear everything; operand_a=digit, count=1; go to S_A.
- A/B/C: chaining. operand_a ← result, operand_b ← 0, latch the operator, go to S_B.
- D: ignored (no repeat).

Display:
- S_A: operand_a.
- S_B: operand_a until the first B digit, then operand_b.
- S_EXEC: last displayed value.
- S_SHOW: result.

Timing and outputs:
- The ALU must sample operand_a, operand_b and op_codificada on start. These outputs are stable from start until S_EXEC exits.
- All outputs are registered. Key-to-output latency is 1 cycle.

Test Plan:
- Keys 1,2,A,3,4,D; alu_done with result 46 after 5 cycles: start high exactly one cycle after D, operand_a=12, operand_b=34, op_codificada=11, busy for 5 cycles, display=46, error=0.
- Keys 9,9,9,9,9: operand_a=9999 (5th digit dropped); then B, C, 5, D: op_codificada=01 (replaced), operand_b=5.
- Result 46 in S_SHOW; keys B,2,D: operand_a=46, op_codificada=10, operand_b=2, start pulse. Then digit 7 in S_SHOW: operand_a=7, state S_A.
- Keys 1,A,2,D with no alu_done for TIMEOUT=255 cycles: error=1 at cycle 255, display=0. Then key E: error=0, all operands 0.
- In S_EXEC, key E and alu_done in the same cycle: state S_A, result not latched, display=0. Separately, alu_err=1 with alu_done: error=1.
- rst asserted mid-S_EXEC (asynchronous, no clock edge): all outputs 0 immediately. A later alu_done pulse is ignored.
